// File: rtl/key_event_ctrl.sv
// Classifies debounced key edges into CLICK/DOUBLE/LONG/REPEAT; events register on the sampling edge (1-cycle latency).
// One-deep event slot held until ev_ready; a new event arriving while the slot is stalled is dropped and sets sticky ovf.
module key_event_ctrl #(
   parameter int LONG_CNT = 50_000_000,
   parameter int DBL_CNT  = 15_000_000,
   parameter int REP_CNT  = 10_000_000,
   parameter int CNT_W    = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_flag,
   input  logic       key_state,
   input  logic       ev_ready,
   input  logic       ovf_clr,
   output logic       ev_valid,
   output logic [2:0] ev_code,
   output logic       ovf,
   output logic       busy
);

   typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, HOLD} state_t;

   localparam logic [2:0] EV_CLICK  = 3'd1;
   localparam logic [2:0] EV_DOUBLE = 3'd2;
   localparam logic [2:0] EV_LONG   = 3'd3;
   localparam logic [2:0] EV_REPEAT = 3'd4;

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
   localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CNT - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CNT - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] timer, timer_nxt;
   logic             emit, drop;
   logic [2:0]       emit_code;
   logic             key_press, key_rel;

   assign key_press = key_flag & ~key_state;
   assign key_rel   = key_flag &  key_state;

   // Key edges are tested before timer expiry so an edge always wins a tie.
   always_comb begin
      state_nxt = state;
      timer_nxt = timer + CNT_W'(1);
      emit      = 1'b0;
      emit_code = 3'd0;
      case (state)
         IDLE:   if (key_press) state_nxt = PRESS1;
         PRESS1: begin
            if (key_rel) state_nxt = WAIT2;
            else if (timer == LONG_LAST) begin
               emit      = 1'b1;
               emit_code = EV_LONG;
               state_nxt = HOLD;
            end
         end
         WAIT2: begin
            if (key_press) state_nxt = PRESS2;
            else if (timer == DBL_LAST) begin
               emit      = 1'b1;
               emit_code = EV_CLICK;
               state_nxt = IDLE;
            end
         end
         PRESS2: begin
            if (key_rel) begin
               emit      = 1'b1;
               emit_code = EV_DOUBLE;
               state_nxt = IDLE;
            end
         end
         HOLD: begin
            if (key_rel) state_nxt = IDLE;
            else if (timer == REP_LAST) begin
               emit      = 1'b1;
               emit_code = EV_REPEAT;
               timer_nxt = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != state) timer_nxt = '0;
   end

   assign drop = emit & ev_valid & ~ev_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         timer    <= '0;
         busy     <= 1'b0;
         ev_valid <= 1'b0;
         ev_code  <= 3'd0;
         ovf      <= 1'b0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         busy  <= (state_nxt != IDLE);
         if (emit && (!ev_valid || ev_ready)) begin
            ev_valid <= 1'b1;
            ev_code  <= emit_code;
         end else if (ev_valid && ev_ready) begin
            ev_valid <= 1'b0;
         end
         if (drop)         ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed timing scenarios plus randomized traffic against a timestamp-based model.
module tb_key_event_ctrl;

   localparam int LONG = 100;
   localparam int DBL  = 40;
   localparam int REP  = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_flag = 1'b0, key_state = 1'b1, ev_ready = 1'b1, ovf_clr = 1'b0;
   logic       ev_valid, ovf, busy;
   logic [2:0] ev_code;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   int         ev_cyc[$];
   logic [2:0] ev_cd[$];

   // Model: mode plus the edge index at which the current interval started.
   localparam int M_IDLE = 0, M_P1 = 1, M_W2 = 2, M_P2 = 3, M_HOLD = 4;
   int         m_mode;
   int         m_t0;
   logic       m_valid, m_ovf, m_busy;
   logic [2:0] m_code;

   key_event_ctrl #(.LONG_CNT(LONG), .DBL_CNT(DBL), .REP_CNT(REP), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .key_flag(key_flag), .key_state(key_state),
      .ev_ready(ev_ready), .ovf_clr(ovf_clr),
      .ev_valid(ev_valid), .ev_code(ev_code), .ovf(ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic model_reset();
      m_mode = M_IDLE; m_t0 = cyc; m_valid = 0; m_ovf = 0; m_busy = 0; m_code = 3'd0;
   endtask

   task automatic model_edge(input logic f, input logic s, input logic rdy, input logic clr);
      bit press, rel, drop;
      int ev, nm, el;
      press = f && !s;
      rel   = f && s;
      ev = 0; drop = 0; nm = m_mode;
      el = cyc - m_t0;
      case (m_mode)
         M_IDLE: if (press) nm = M_P1;
         M_P1:   if (rel) nm = M_W2; else if (el == LONG) begin ev = 3; nm = M_HOLD; end
         M_W2:   if (press) nm = M_P2; else if (el == DBL) begin ev = 1; nm = M_IDLE; end
         M_P2:   if (rel) begin ev = 2; nm = M_IDLE; end
         default: if (rel) nm = M_IDLE; else if (el == REP) begin ev = 4; m_t0 = cyc; end
      endcase
      if (nm != m_mode) m_t0 = cyc;
      m_mode = nm;
      if (ev != 0) begin
         if (!m_valid || rdy) begin m_valid = 1; m_code = 3'(ev); end
         else drop = 1;
      end else if (m_valid && rdy) m_valid = 0;
      if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
      m_busy = (m_mode != M_IDLE);
   endtask

   task automatic tick(input logic f, input logic s, input logic rdy, input logic clr);
      logic was_v, acc;
      int e;
      @(negedge clk);
      key_flag = f; key_state = s; ev_ready = rdy; ovf_clr = clr;
      was_v = ev_valid;
      acc   = ev_valid && rdy;
      @(posedge clk);
      e = cyc;
      model_edge(f, s, rdy, clr);
      cyc++;
      #1;
      key_flag = 0; ovf_clr = 0;
      if (ev_valid && (!was_v || acc)) begin
         ev_cyc.push_back(e);
         ev_cd.push_back(ev_code);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid got=%b exp=0", ev_valid); end
      checks++; if (ev_code !== 3'd0) begin errors++; $display("FAIL reset_ev_code got=%0d exp=0", ev_code); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_click();
      int r;
      ev_cyc.delete(); ev_cd.delete();
      tick(1, 0, 1, 0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL click_first_press_busy got=%b exp=1", busy); end
      repeat (9) tick(0, 0, 1, 0);
      r = cyc;
      tick(1, 1, 1, 0);
      repeat (50) tick(0, 1, 1, 0);
      checks++;
      if (ev_cyc.size() != 1) begin errors++; $display("FAIL click_count got=%0d exp=1", ev_cyc.size()); end
      else begin
         if (ev_cd[0] !== 3'd1) begin errors++; $display("FAIL click_code got=%0d exp=1", ev_cd[0]); end
         checks++;
         if (ev_cyc[0] != r + DBL) begin errors++; $display("FAIL click_time got=%0d exp=%0d", ev_cyc[0], r + DBL); end
      end
      checks++; if (busy !== 1'b0 || ev_valid !== 1'b0) begin errors++; $display("FAIL click_after busy=%b valid=%b exp=0,0", busy, ev_valid); end
   endtask

   task automatic test_double();
      int r2;
      ev_cyc.delete(); ev_cd.delete();
      tick(1, 0, 1, 0);
      repeat (4) tick(0, 0, 1, 0);
      tick(1, 1, 1, 0);
      repeat (19) tick(0, 1, 1, 0);
      tick(1, 0, 1, 0);
      repeat (4) tick(0, 0, 1, 0);
      r2 = cyc;
      tick(1, 1, 1, 0);
      repeat (50) tick(0, 1, 1, 0);
      checks++;
      if (ev_cyc.size() != 1) begin errors++; $display("FAIL double_count got=%0d exp=1", ev_cyc.size()); end
      else begin
         if (ev_cd[0] !== 3'd2) begin errors++; $display("FAIL double_code got=%0d exp=2", ev_cd[0]); end
         checks++;
         if (ev_cyc[0] != r2) begin errors++; $display("FAIL double_time got=%0d exp=%0d", ev_cyc[0], r2); end
      end
   endtask

   task automatic test_long_repeat();
      int p;
      int         exp_t[3];
      logic [2:0] exp_c[3];
      ev_cyc.delete(); ev_cd.delete();
      p = cyc;
      exp_t[0] = p + 100; exp_t[1] = p + 120; exp_t[2] = p + 140;
      exp_c[0] = 3'd3;    exp_c[1] = 3'd4;    exp_c[2] = 3'd4;
      tick(1, 0, 1, 0);
      repeat (144) tick(0, 0, 1, 0);
      tick(1, 1, 1, 0);
      repeat (20) tick(0, 1, 1, 0);
      checks++;
      if (ev_cyc.size() != 3) begin errors++; $display("FAIL long_count got=%0d exp=3", ev_cyc.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (ev_cd[i] !== exp_c[i] || ev_cyc[i] != exp_t[i]) begin
               errors++;
               $display("FAIL long_ev%0d got code=%0d t=%0d exp code=%0d t=%0d", i, ev_cd[i], ev_cyc[i], exp_c[i], exp_t[i]);
            end
         end
      end
   endtask

   task automatic test_release_at_expiry();
      int p;
      ev_cyc.delete(); ev_cd.delete();
      p = cyc;
      tick(1, 0, 1, 0);
      repeat (99) tick(0, 0, 1, 0);
      tick(1, 1, 1, 0);
      repeat (50) tick(0, 1, 1, 0);
      checks++;
      if (ev_cyc.size() != 1) begin errors++; $display("FAIL tie_count got=%0d exp=1", ev_cyc.size()); end
      else begin
         if (ev_cd[0] !== 3'd1) begin errors++; $display("FAIL tie_code got=%0d exp=1", ev_cd[0]); end
         checks++;
         if (ev_cyc[0] != p + 140) begin errors++; $display("FAIL tie_time got=%0d exp=%0d", ev_cyc[0], p + 140); end
      end
   endtask

   task automatic test_overflow();
      tick(1, 0, 0, 0);
      repeat (125) tick(0, 0, 0, 0);
      checks++;
      if (ev_valid !== 1'b1 || ev_code !== 3'd3 || ovf !== 1'b1) begin
         errors++; $display("FAIL ovf_drop got valid=%b code=%0d ovf=%b exp 1,3,1", ev_valid, ev_code, ovf);
      end
      tick(1, 1, 0, 0);
      checks++; if (busy !== 1'b0 || ev_valid !== 1'b1) begin errors++; $display("FAIL ovf_idle_pending busy=%b valid=%b exp 0,1", busy, ev_valid); end
      tick(0, 1, 0, 1);
      checks++;
      if (ovf !== 1'b0 || ev_valid !== 1'b1 || ev_code !== 3'd3) begin
         errors++; $display("FAIL ovf_clr got ovf=%b valid=%b code=%0d exp 0,1,3", ovf, ev_valid, ev_code);
      end
      tick(0, 1, 1, 0);
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL ovf_accept got valid=%b exp=0", ev_valid); end
   endtask

   task automatic test_reset_mid();
      int r;
      tick(1, 0, 0, 0);
      repeat (105) tick(0, 0, 0, 0);
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if (ev_valid !== 1'b0 || ev_code !== 3'd0 || ovf !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL midreset got valid=%b code=%0d ovf=%b busy=%b exp all 0", ev_valid, ev_code, ovf, busy);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      ev_ready = 1'b1;
      ev_cyc.delete(); ev_cd.delete();
      tick(1, 0, 1, 0);
      repeat (4) tick(0, 0, 1, 0);
      r = cyc;
      tick(1, 1, 1, 0);
      repeat (50) tick(0, 1, 1, 0);
      checks++;
      if (ev_cyc.size() != 1 || ev_cd[0] !== 3'd1 || ev_cyc[0] != r + DBL) begin
         errors++; $display("FAIL midreset_click count=%0d exp 1 CLICK at %0d", ev_cyc.size(), r + DBL);
      end
   endtask

   task automatic test_random();
      logic f, s, rdy, clr;
      int rate;
      for (int i = 0; i < 3000; i++) begin
         rate = ((i / 500) % 2 == 1) ? 150 : 15;
         f   = ($urandom_range(0, rate - 1) == 0);
         s   = 1'($urandom_range(0, 1));
         rdy = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 15) == 0);
         tick(f, s, rdy, clr);
         checks++;
         if (ev_valid !== m_valid || (m_valid && ev_code !== m_code) || ovf !== m_ovf || busy !== m_busy) begin
            errors++;
            $display("FAIL random cyc=%0d got v=%b c=%0d o=%b b=%b exp v=%b c=%0d o=%b b=%b",
                     cyc, ev_valid, ev_code, ovf, busy, m_valid, m_code, m_ovf, m_busy);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_click();
      test_double();
      test_long_repeat();
      test_release_at_expiry();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
